// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Parameterised synchronous FIFO with occupancy count, almost
//               flags, sticky overflow/underflow and registered or FWFT read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = (1 << ADDR_W) - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_words,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [ADDR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [ADDR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [ADDR_W:0]   r_words_q,  w_words_d;
    logic              r_ovf_q,    w_ovf_d;
    logic              r_unf_q,    w_unf_d;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (int'(r_words_q) == c_DEPTH);
    assign w_empty  = (r_words_q == '0);
    assign w_rd_acc = rd_en & ~w_empty;
    // A write into a full FIFO is legal only when a read frees the slot in the same edge.
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_words_d  = r_words_q;
        if (w_wr_acc) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_words_d = r_words_q + 1'b1;
            2'b01:   w_words_d = r_words_q - 1'b1;
            default: w_words_d = r_words_q;
        endcase
        // New errors take priority over the clear.
        w_ovf_d = (wr_en & ~w_wr_acc) | (r_ovf_q & ~clr_err);
        w_unf_d = (rd_en & w_empty)   | (r_unf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_words_q  <= '0;
            r_ovf_q    <= 1'b0;
            r_unf_q    <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_words_q  <= w_words_d;
            r_ovf_q    <= w_ovf_d;
            r_unf_q    <= w_unf_d;
        end
    end

    // Storage is not reset; occupancy accounting alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = w_empty ? '0 : r_mem[r_rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] r_dout_q, w_dout_d;

            always_comb begin
                w_dout_d = r_dout_q;
                if (w_rd_acc) begin
                    w_dout_d = r_mem[r_rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_dout_q <= '0;
                end else begin
                    r_dout_q <= w_dout_d;
                end
            end

            assign data_out = r_dout_q;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (int'(r_words_q) >= AF_THRESH);
    assign almost_empty = (int'(r_words_q) <= AE_THRESH);
    assign fifo_words   = r_words_q;
    assign overflow     = r_ovf_q;
    assign underflow    = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Directed scoreboard bench for fifo_param, registered and FWFT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [7:0] data_out;
    logic [3:0] fifo_words;

    logic       f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;
    logic [7:0] f_data_out;
    logic [3:0] f_fifo_words;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_dout = 8'h00;
    string      stage = "init";

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .data_out(data_out),
        .empty(empty), .almost_empty(almost_empty), .fifo_words(fifo_words),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .full(f_full), .almost_full(f_almost_full), .rd_en(rd_en), .data_out(f_data_out),
        .empty(f_empty), .almost_empty(f_almost_empty), .fifo_words(f_fifo_words),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=0x%0h expected=0x%0h", stage, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = sb.size();
        chk("words",     32'(fifo_words),   32'(n));
        chk("full",      32'(full),         32'(n == 8));
        chk("empty",     32'(empty),        32'(n == 0));
        chk("afull",     32'(almost_full),  32'(n >= 6));
        chk("aempty",    32'(almost_empty), 32'(n <= 1));
        chk("overflow",  32'(overflow),     32'(m_ovf));
        chk("underflow", 32'(underflow),    32'(m_unf));
        chk("dout_reg",  32'(data_out),     32'(m_dout));
        chk("dout_fwft", 32'(f_data_out),   (n > 0) ? 32'(sb[0]) : 32'h0);
        chk("fwft_words", 32'(f_fifo_words), 32'(n));
        chk("fwft_flags", 32'({f_full, f_empty, f_overflow, f_underflow}),
            32'({n == 8, n == 0, m_ovf, m_unf}));
    endtask

    // One clock: drive inputs, update the reference model at the edge, then compare.
    task automatic cyc(input bit rst, input bit we, input logic [7:0] wd,
                       input bit re, input bit clr);
        int n;
        bit ra, wa;
        rst_n   = !rst;
        wr_en   = we;
        data_in = wd;
        rd_en   = re;
        clr_err = clr;
        n  = sb.size();
        ra = re && (n > 0);
        wa = we && ((n < 8) || ra);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = 8'h00;
        end else begin
            m_ovf = (we && !wa) || (m_ovf && !clr);
            m_unf = (re && (n == 0)) || (m_unf && !clr);
            if (ra) m_dout = sb.pop_front();
            if (wa) sb.push_back(wd);
        end
        #1;
        check_all();
    endtask

    initial begin
        stage = "reset";
        cyc(1, 1, 8'h33, 1, 0);
        cyc(1, 1, 8'h44, 1, 1);

        stage = "fill";
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h10 + i), 0, 0);
        stage = "overfill";
        cyc(0, 1, 8'hFF, 0, 0);
        chk("ovf_set", 32'(overflow), 32'h1);
        stage = "clr_ovf";
        cyc(0, 0, 8'h00, 0, 1);

        stage = "drain";
        for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, 1, 0);
        stage = "underread";
        cyc(0, 0, 8'h00, 1, 0);
        chk("dout_hold", 32'(data_out), 32'h17);
        chk("unf_set", 32'(underflow), 32'h1);
        stage = "clr_unf";
        cyc(0, 0, 8'h00, 0, 1);

        stage = "refill";
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h20 + i), 0, 0);
        stage = "full_rw";
        cyc(0, 1, 8'hAA, 1, 0);
        chk("full_rw_cnt", 32'(fifo_words), 32'd8);
        stage = "drain2";
        for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, 1, 0);
        chk("last_aa", 32'(data_out), 32'hAA);

        stage = "fwft";
        cyc(0, 1, 8'h5A, 0, 0);
        chk("fwft_5a", 32'(f_data_out), 32'h5A);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        chk("fwft_zero", 32'(f_data_out), 32'h0);

        stage = "wrap";
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 8'(8'h40 + i), 0, 0);
            chk("wrap_max", 32'(fifo_words <= 4'd1), 32'h1);
            cyc(0, 0, 8'h00, 1, 0);
        end

        stage = "clr_vs_ovf";
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h70 + i), 0, 0);
        cyc(0, 1, 8'hEE, 0, 0);
        cyc(0, 1, 8'hEF, 0, 1);
        chk("ovf_wins", 32'(overflow), 32'h1);

        stage = "mid_reset";
        cyc(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h90 + i), 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 1, 8'h95, 0, 0);
        chk("pre_rst_cnt", 32'(fifo_words), 32'd5);
        cyc(1, 1, 8'h99, 1, 0);
        chk("rst_dout", 32'(data_out), 32'h0);
        stage = "post_reset";
        cyc(0, 1, 8'hC3, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, log2 of depth; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full threshold in words.
REQ-004 SHALL have parameter AE_THRESH, default 1, almost_empty threshold in words.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports, one per line:
 clk  in  1  clock, rising edge
 rst_n  in  1  reset, synchronous, active-low
 wr_en  in  1  write request
 data_in  in  DATA_W  write data
 full  out  1  no free entries
 almost_full  out  1  fifo_words >= AF_THRESH
 rd_en  in  1  read request
 data_out  out  DATA_W  read data
 empty  out  1  no stored entries
 almost_empty  out  1  fifo_words <= AE_THRESH
 fifo_words  out  ADDR_W+1  current occupancy, 0..DEPTH
 overflow  out  1  sticky: write rejected
 underflow  out  1  sticky: read rejected
 clr_err  in  1  clears overflow/underflow

Function
REQ-007 SHALL accept a read (rd_acc) when rd_en=1 and empty=0.
REQ-008 SHALL accept a write (wr_acc) when wr_en=1 and (full=0 or rd_acc=1); write while full is accepted only with a simultaneous accepted read.
REQ-009 SHALL store data_in at wr_ptr and increment wr_ptr modulo DEPTH on wr_acc; SHALL increment rd_ptr modulo DEPTH on rd_acc.
REQ-010 SHALL update fifo_words: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
REQ-011 SHALL derive full, empty, almost_full and almost_empty combinationally from fifo_words.
REQ-012 FWFT=0: SHALL register mem[rd_ptr] to data_out on the clock edge of rd_acc (valid one cycle after rd_en); data_out SHALL hold otherwise.
REQ-013 FWFT=1: data_out SHALL equal mem[rd_ptr] whenever empty=0 and SHALL be 0 when empty=1; rd_acc pops the presented word; a word written into an empty FIFO appears on data_out the cycle after the write edge.
REQ-014 Simultaneous rd_acc and wr_acc on the same entry (count=DEPTH) SHALL return old data and store new data without corruption.
REQ-015 SHALL set overflow on any edge with wr_en=1 and wr_acc=0; SHALL set underflow on any edge with rd_en=1 and empty=1.
REQ-016 clr_err=1 SHALL clear overflow and underflow at the next edge; a new error in the same cycle SHALL win (flag remains 1).
REQ-017 Rejected requests SHALL not change pointers, fifo_words, memory or data_out.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 without affecting occupancy accounting.

Reset
REQ-019 When rst_n=0 at a clock edge, SHALL set wr_ptr=0, rd_ptr=0, fifo_words=0, overflow=0, underflow=0, data_out=0, regardless of wr_en/rd_en; memory contents need not be cleared.
REQ-020 Reset mid-operation SHALL discard all stored words; empty=1, almost_empty=1, full=0 in the cycle after reset.

Verification (DATA_W=8, ADDR_W=3, AF_THRESH=6, AE_THRESH=1)
REQ-021 Fill: write 0x10..0x17 on 8 edges -> fifo_words 8, full=1, almost_full=1 from count 6; 9th write 0xFF -> rejected, overflow=1, count stays 8.
REQ-022 Drain FWFT=0: after fill, 8 reads -> data_out 0x10..0x17 each one cycle after rd_en; 9th read -> underflow=1, data_out holds 0x17, empty=1.
REQ-023 Full simultaneous: at count 8 assert wr_en (0xAA) and rd_en -> count stays 8, no overflow; the later drain ends with 0xAA after the seven remaining old words.
REQ-024 FWFT=1: write 0x5A to empty -> next cycle empty=0, data_out=0x5A with no rd_en; rd_en one cycle -> empty=1, data_out=0.
REQ-025 Wrap: 20 interleaved write/read pairs with incrementing data -> data order preserved, count never exceeds 1; clr_err with simultaneous rejected write -> overflow remains 1.
REQ-026 Reset at count 5 -> next cycle fifo_words=0, empty=1, overflow=0, underflow=0, data_out=0.
